// File: rtl/seq_det_scheduler.sv
// Time-shares one sequence detector between N_REQ requesters: round-robin pick,
// clear the detector, shift the word in MSB-first, count match pulses, report.
module seq_det_scheduler #(
  parameter  int N_REQ   = 4,
  parameter  int WORD_W  = 8,
  parameter  int DET_LAT = 1,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WORD_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     det_reset,
  output logic                     det_data,
  input  logic                     det_match,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CNT_W-1:0]         rsp_count,
  output logic                     busy
);

  localparam int DL_W = $clog2(DET_LAT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [WORD_W-1:0] r_shift;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [DL_W-1:0]   r_drainCnt;

  logic              w_found;
  logic [ID_W-1:0]   w_gntIdx;
  logic [ID_W-1:0]   w_candIdx;
  logic [N_REQ-1:0]  w_reqReady;
  logic              w_countEn;

  // Scan from the requester after the last grant, wrapping, so a continuously
  // valid requester cannot be picked again while another one is waiting.
  always_comb begin
    w_found   = 1'b0;
    w_gntIdx  = '0;
    w_candIdx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_candIdx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_candIdx]) begin
        w_found  = 1'b1;
        w_gntIdx = w_candIdx;
      end
    end
  end

  always_comb begin
    w_reqReady = '0;
    if (r_state == S_IDLE && w_found) begin
      w_reqReady[w_gntIdx] = 1'b1;
    end
  end

  assign w_countEn = det_match && (r_state == S_SHIFT || r_state == S_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= ID_W'(N_REQ - 1);
      r_shift    <= '0;
      r_id       <= '0;
      r_count    <= '0;
      r_bitCnt   <= '0;
      r_drainCnt <= '0;
    end else begin
      if (w_countEn) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_shift <= req_data[w_gntIdx*WORD_W +: WORD_W];
            r_id    <= w_gntIdx;
            r_ptr   <= w_gntIdx;
            r_count <= '0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_bitCnt <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
          if (r_bitCnt == CNT_W'(WORD_W - 1)) begin
            r_drainCnt <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
          end
        end
        // The last pulse arrives DET_LAT cycles after the last bit went out.
        S_DRAIN: begin
          if (r_drainCnt == DL_W'(DET_LAT - 1)) begin
            r_state <= S_REPORT;
          end else begin
            r_drainCnt <= r_drainCnt + DL_W'(1);
          end
        end
        S_REPORT: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_reqReady;
  assign det_reset = reset | (r_state == S_CLEAR);
  assign det_data  = (r_state == S_SHIFT) & r_shift[WORD_W-1];
  assign rsp_valid = (r_state == S_REPORT);
  assign rsp_id    = r_id;
  assign rsp_count = r_count;
  assign busy      = (r_state != S_IDLE);

endmodule
